// File: rtl/fetch_controller_if.sv
// Fetch-side bundle: instruction-memory port, redirect/halt controls, and the decode handshake.
// FETCH_PERF_EN adds the fetch/stall counter outputs.
interface fetch_controller_if;
    logic [31:0] imem_addr_o;
    logic        imem_en_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        done_o;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;

    modport master (
        output imem_addr_o, imem_en_o, valid_o, instr_o, pc_o, done_o, fetch_cnt_o, stall_cnt_o,
        input  imem_instr_i, redirect_i, redirect_pc_i, halt_i, ready_i
    );
    modport slave (
        input  imem_addr_o, imem_en_o, valid_o, instr_o, pc_o, done_o, fetch_cnt_o, stall_cnt_o,
        output imem_instr_i, redirect_i, redirect_pc_i, halt_i, ready_i
    );
`else
    modport master (
        output imem_addr_o, imem_en_o, valid_o, instr_o, pc_o, done_o,
        input  imem_instr_i, redirect_i, redirect_pc_i, halt_i, ready_i
    );
    modport slave (
        input  imem_addr_o, imem_en_o, valid_o, instr_o, pc_o, done_o,
        output imem_instr_i, redirect_i, redirect_pc_i, halt_i, ready_i
    );
`endif
endinterface

// File: rtl/fetch_controller.sv
// Fetch PC owner + prefetch FIFO; a word fetched at edge N is at the head after edge N; fetch stops
// when the FIFO is full with no pop (ready_i low), on halt, or at end of program. FETCH_PERF_EN adds counters.
module fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MEM_DEPTH  = 12
) (
    input  logic               clk,
    input  logic               rst,
    fetch_controller_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [31:0]   NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {S_FETCH, S_HALT, S_END} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          done;
    entry_t        fifo_mem [FIFO_DEPTH];
    entry_t        head;

    logic          empty, full, pop, push;
    logic [31:0]   redirect_pc_al;

    function automatic logic in_range(input logic [31:0] pc);
        return {2'b00, pc[31:2]} < 32'(MEM_DEPTH);
    endfunction

    assign empty          = (count == '0);
    assign full           = (count == FULL_CNT);
    assign pop            = !empty && bus.ready_i;
    assign redirect_pc_al = {bus.redirect_pc_i[31:2], 2'b00};
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push = !rst && (state == S_FETCH) && !bus.redirect_i && !bus.halt_i
                  && in_range(fetch_pc) && (!full || pop);

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        count_nxt    = count;
        if (bus.redirect_i) begin
            fetch_pc_nxt = redirect_pc_al;
            count_nxt    = '0;
            if (!in_range(redirect_pc_al))
                state_nxt = S_END;
            else if (bus.halt_i)
                state_nxt = S_HALT;
            else
                state_nxt = S_FETCH;
        end else begin
            if (push)
                fetch_pc_nxt = fetch_pc + 32'd4;
            count_nxt = count + CW'(push) - CW'(pop);
            case (state)
                S_FETCH: begin
                    if (!in_range(fetch_pc_nxt))
                        state_nxt = S_END;
                    else if (bus.halt_i)
                        state_nxt = S_HALT;
                end
                S_HALT: begin
                    if (!bus.halt_i)
                        state_nxt = in_range(fetch_pc) ? S_FETCH : S_END;
                end
                S_END:   state_nxt = S_END;
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            count    <= count_nxt;
            done     <= (state_nxt == S_END) && (count_nxt == '0);
            if (bus.redirect_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: the head is only exposed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{pc: fetch_pc, instr: bus.imem_instr_i};
    end

    assign head            = fifo_mem[rd_ptr];
    assign bus.imem_addr_o = fetch_pc;
    assign bus.imem_en_o   = push;
    assign bus.valid_o     = !empty;
    assign bus.instr_o     = empty ? NOP : head.instr;
    assign bus.pc_o        = empty ? 32'h0 : head.pc;
    assign bus.done_o      = done;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push && fetch_cnt != 32'hFFFF_FFFF)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (state == S_FETCH && full && !pop && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.fetch_cnt_o = fetch_cnt;
    assign bus.stall_cnt_o = stall_cnt;
`endif
endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the combinational instruction memory: owns the fetch PC, drives the memory address and enable, and buffers fetched words in a small prefetch FIFO.
- Delivers {pc, instr} pairs to decode over a valid/ready handshake.
- Handles control-flow redirects (branch/jump), external halt, and end-of-program detection.
- Sits between the PC/branch logic and the instruction memory at the front of the pipeline.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned.
- FIFO_DEPTH, 4, prefetch entries; power of two, minimum 2.
- MEM_DEPTH, 12, instruction-memory depth in words. A fetch word index >= MEM_DEPTH is end of program.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr_o  out  32  byte address to instruction memory; equals fetch_pc.
- imem_en_o  out  1  memory enable; high only in a push cycle.
- imem_instr_i  in  32  combinational read data from memory.
- redirect_i  in  1  one-cycle pulse that flushes the FIFO and reloads fetch_pc.
- redirect_pc_i  in  32  redirect target.
- halt_i  in  1  level; while high, no new fetches.
- valid_o  out  1  FIFO head is valid.
- ready_i  in  1  decode accepts the head.
- instr_o  out  32  head instruction; 32'h0000_0013 (NOP) when valid_o=0.
- pc_o  out  32  head PC; 0 when valid_o=0.
- done_o  out  1  end of program reached and FIFO empty.

Behaviour:
- Reset (async, immediate):
  - fetch_pc=RESET_PC; FIFO empty; state=FETCH.
  - valid_o=0, instr_o=32'h13, pc_o=0, done_o=0, imem_en_o=0, imem_addr_o=RESET_PC.
  - Reset mid-operation discards all FIFO contents.
- States:
  - FETCH: actively fetching.
  - HALT: halt_i high.
  - END: fetch_pc>>2 >= MEM_DEPTH.
- Transitions:
  - FETCH->HALT when halt_i=1. HALT->FETCH when halt_i=0.
  - FETCH->END when the next fetch index >= MEM_DEPTH.
  - END stays in END until redirect or reset.
  - Redirect from any state goes to FETCH, or to HALT if halt_i=1, or to END if the target index >= MEM_DEPTH.
- Push: in FETCH, when the FIFO is not full, or it is full and a pop occurs in the same cycle:
  - imem_en_o=1; the entry {fetch_pc, imem_instr_i} is written; fetch_pc += 4 (32-bit wrap).
  - The fetch-to-output latency is 1 cycle: a word pushed at edge N is visible at the head after edge N.
- Pop: valid_o && ready_i at the clock edge. Simultaneous push and pop on a full FIFO is legal; the occupancy is unchanged.
- Redirect has priority over push and pop:
  - FIFO is flushed; any same-cycle pop is ignored; no push occurs that cycle.
  - fetch_pc = {redirect_pc_i[31:2], 2'b00}.
  - valid_o=0 in the following cycle.
  - Fetching resumes the cycle after the redirect.
- Halt and END: no pushes, imem_en_o=0, and the FIFO keeps draining to decode.
- Occupancy: counter of width clog2(FIFO_DEPTH)+1; read and write pointers wrap modulo FIFO_DEPTH.
- done_o = (state==END) && FIFO empty. This is registered consistently with the state and clears on redirect.

Optional Feature:
- Macro FETCH_PERF_EN.
- With the macro defined:
  - Adds outputs fetch_cnt_o[31:0] and stall_cnt_o[31:0], both 0 at reset.
  - fetch_cnt_o increments on every push.
  - stall_cnt_o increments on every cycle in FETCH with the FIFO full and no pop.
  - Both counters saturate at 32'hFFFF_FFFF and are not cleared by redirect.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0 and ready_i=1 -> imem_addr_o sequences 0,4,8. valid_o rises the cycle after reset release, then pc_o=0,4,8 with instr_o = mem[0], mem[1], mem[2].
- ready_i=0 for 6 cycles -> exactly 4 pushes, then imem_en_o=0. Raising ready_i then drains pc 0,4,8,12 in order, with no loss or duplication.
- Redirect to 32'h0000_0012 while the FIFO holds 3 entries -> the next cycle has valid_o=0 and fetch_pc=0x10. The next delivered pc_o=0x10; the old entries never appear.
- MEM_DEPTH=12 with ready_i=1 -> the last push is pc=0x2C. imem_en_o stays 0 afterwards, and done_o=1 after pc 0x2C is popped.
- halt_i high for 5 cycles with ready_i=1 -> no pushes, the FIFO drains, and valid_o falls. Dropping halt_i resumes fetching at the next sequential PC.
- Assert rst mid-stream while the FIFO is full -> valid_o=0 and instr_o=32'h13 immediately (asynchronously), and fetching restarts at RESET_PC.
